regfile_load_writer: RTL and testbench

//  Write-side sequencer for the register file (accumulator plus general registers). It queues

---
 rtl/regfile_load_writer.sv | 203 ++++++++++++++++++++
 tb/tb_regfile_load_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_load_writer.sv
// Write-side sequencer for the register file.
// Queues load requests, reads each one from the 1-cycle synchronous data
// memory and retires it through the shared register-file write port.
// ALU results use the same port with zero latency; an ALU write that would
// overtake a pending load to the same register is stalled instead.
module regfile_load_writer #(
    parameter int W     = 8,
    parameter int D     = 2,
    parameter int A     = 8,
    parameter int DEPTH = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AluValid,
    input  logic         AluDest,
    input  logic [D-1:0] AluAddr,
    input  logic [W-1:0] AluData,
    output logic         AluStall,
    input  logic         LdValid,
    output logic         LdReady,
    input  logic         LdDest,
    input  logic [D-1:0] LdAddr,
    input  logic [A-1:0] LdMemAddr,
    output logic         MemRdEn,
    output logic [A-1:0] MemAddr,
    input  logic [W-1:0] MemData,
    output logic         WriteEn,
    output logic         Destination,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         Busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RESP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);

    // Pending-load queue storage and control
    logic         r_q_dest [DEPTH];
    logic [D-1:0] r_q_addr [DEPTH];
    logic [A-1:0] r_q_mem  [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    // Sequencer state and the load currently being retired
    logic [1:0]   r_state;
    logic         r_cur_dest;
    logic [D-1:0] r_cur_addr;
    logic [W-1:0] r_hold_data;

    logic         w_ld_ready;
    logic         w_push;
    logic         w_pop;
    logic         w_hazard;
    logic         w_stall;
    logic         w_alu_go;
    logic [PW-1:0] w_idx;
    logic [1:0]   w_next_state;
    logic         w_we;
    logic         w_dest;
    logic [D-1:0] w_addr;
    logic [W-1:0] w_data;
    logic         w_rd_en;
    logic [A-1:0] w_rd_addr;

    // Two targets collide when both are the accumulator, or the same general register
    function automatic logic f_match(input logic d1, input logic [D-1:0] a1,
                                     input logic d2, input logic [D-1:0] a2);
        return (!d1 && !d2) || (d1 && d2 && (a1 == a2));
    endfunction

    assign w_ld_ready = (r_count != L_FULL);
    assign w_push     = LdValid && w_ld_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);

    // Scan every occupied queue slot plus the in-flight/held load for an ALU target clash
    always_comb begin
        w_hazard = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr + PW'(k);
            if (((PW+1)'(k) < r_count) &&
                f_match(AluDest, AluAddr, r_q_dest[w_idx], r_q_addr[w_idx]))
                w_hazard = 1'b1;
        end
        if ((r_state != S_IDLE) && f_match(AluDest, AluAddr, r_cur_dest, r_cur_addr))
            w_hazard = 1'b1;
    end

    assign w_stall  = AluValid && ((r_state == S_HOLD) || w_hazard);
    assign w_alu_go = AluValid && !w_stall;

    // Write-port arbitration, memory read strobe and next-state selection
    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_dest       = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_alu_go) begin
                    w_we   = 1'b1;
                    w_dest = AluDest;
                    w_addr = AluAddr;
                    w_data = AluData;
                end
                if (w_pop) begin
                    w_rd_en      = 1'b1;
                    w_rd_addr    = r_q_mem[r_rptr];
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_we = 1'b1;
                if (w_alu_go) begin
                    w_dest       = AluDest;
                    w_addr       = AluAddr;
                    w_data       = AluData;
                    w_next_state = S_HOLD;
                end else begin
                    w_dest       = r_cur_dest;
                    w_addr       = r_cur_addr;
                    w_data       = MemData;
                    w_next_state = S_IDLE;
                end
            end
            S_HOLD: begin
                w_we         = 1'b1;
                w_dest       = r_cur_dest;
                w_addr       = r_cur_addr;
                w_data       = r_hold_data;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Queue pointers and occupancy
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end

    // Queue entry storage, written at the tail on each accepted load
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_dest[i] <= 1'b0;
                r_q_addr[i] <= '0;
                r_q_mem[i]  <= '0;
            end
        end else if (w_push) begin
            r_q_dest[r_wptr] <= LdDest;
            r_q_addr[r_wptr] <= LdAddr;
            r_q_mem[r_wptr]  <= LdMemAddr;
        end
    end

    // Sequencer state, in-flight load target and bumped-load hold register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cur_dest  <= 1'b0;
            r_cur_addr  <= '0;
            r_hold_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_cur_dest <= r_q_dest[r_rptr];
                r_cur_addr <= r_q_addr[r_rptr];
            end
            if ((r_state == S_RESP) && w_alu_go)
                r_hold_data <= MemData;
        end
    end

    // Outputs are forced quiet while reset is held; Waddr is zero for accumulator writes
    assign WriteEn     = Reset && w_we;
    assign Destination = Reset && w_we && w_dest;
    assign Waddr       = (Reset && w_we && w_dest) ? w_addr : '0;
    assign DataIn      = (Reset && w_we) ? w_data : '0;
    assign MemRdEn     = Reset && w_rd_en;
    assign MemAddr     = (Reset && w_rd_en) ? w_rd_addr : '0;
    assign AluStall    = Reset && w_stall;
    assign Busy        = Reset && ((r_count != '0) || (r_state != S_IDLE));
    assign LdReady     = !Reset || w_ld_ready;

endmodule

// File: tb/tb_regfile_load_writer.sv
// Directed bench for regfile_load_writer: behavioural 1-cycle data memory,
// a write-port logger, and a linear sequence of hand-checked steps.
module tb_regfile_load_writer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       AluValid, AluDest;
    logic [1:0] AluAddr;
    logic [7:0] AluData;
    logic       AluStall;
    logic       LdValid, LdReady, LdDest;
    logic [1:0] LdAddr;
    logic [7:0] LdMemAddr;
    logic       MemRdEn;
    logic [7:0] MemAddr;
    logic [7:0] MemData;
    logic       WriteEn, Destination;
    logic [1:0] Waddr;
    logic [7:0] DataIn;
    logic       Busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem [256];
    logic [10:0] wr_log [$];
    logic [7:0]  acc_q [$];

    regfile_load_writer #(.W(8), .D(2), .A(8), .DEPTH(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluValid(AluValid), .AluDest(AluDest), .AluAddr(AluAddr), .AluData(AluData),
        .AluStall(AluStall),
        .LdValid(LdValid), .LdReady(LdReady), .LdDest(LdDest), .LdAddr(LdAddr),
        .LdMemAddr(LdMemAddr),
        .MemRdEn(MemRdEn), .MemAddr(MemAddr), .MemData(MemData),
        .WriteEn(WriteEn), .Destination(Destination), .Waddr(Waddr), .DataIn(DataIn),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemRdEn) MemData <= mem[MemAddr];
    end

    always @(negedge Clk) begin
        #2;
        if (WriteEn) wr_log.push_back({Destination, Waddr, DataIn});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic port_chk(input string tag, input logic we, input logic de,
                            input logic [1:0] wa, input logic [7:0] di);
        chk({tag, ".we"}, 32'(WriteEn), 32'(we));
        chk({tag, ".dest"}, 32'(Destination), 32'(de));
        chk({tag, ".waddr"}, 32'(Waddr), 32'(wa));
        chk({tag, ".data"}, 32'(DataIn), 32'(di));
    endtask

    initial begin
        int cyc;
        logic [7:0] ma;
        logic saw_nr;
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0 + 8'(i);
        mem[8'h10] = 8'hA5;
        mem[8'h20] = 8'h77;
        mem[8'h30] = 8'h5E;
        MemData = '0;
        Reset = 1'b0;
        AluValid = 0; AluDest = 0; AluAddr = 0; AluData = 0;
        LdValid = 0; LdDest = 0; LdAddr = 0; LdMemAddr = 0;

        // reset state, with an ALU request pending that must be ignored
        @(negedge Clk); AluValid = 1; AluDest = 1; AluAddr = 1; AluData = 8'h12;
        #1;
        chk("rst.we", 32'(WriteEn), 0);
        chk("rst.rd", 32'(MemRdEn), 0);
        chk("rst.stall", 32'(AluStall), 0);
        chk("rst.busy", 32'(Busy), 0);
        chk("rst.ready", 32'(LdReady), 1);
        @(negedge Clk); AluValid = 0; Reset = 1'b1;

        // ALU writes in IDLE: general register and accumulator (Waddr forced 0)
        @(negedge Clk); AluValid = 1; AluDest = 1; AluAddr = 3; AluData = 8'h4B;
        #1; port_chk("alu_gr", 1, 1, 3, 8'h4B); chk("alu_gr.stall", 32'(AluStall), 0);
        @(negedge Clk); AluDest = 0; AluAddr = 2; AluData = 8'h66;
        #1; port_chk("alu_acc", 1, 0, 0, 8'h66);
        @(negedge Clk); AluValid = 0;
        #1; port_chk("quiet", 0, 0, 0, 0);

        // basic load latency: reg2 <- mem[0x10]
        @(negedge Clk); LdValid = 1; LdDest = 1; LdAddr = 2; LdMemAddr = 8'h10;
        #1; chk("ld.ready", 32'(LdReady), 1);
        @(negedge Clk); LdValid = 0;
        #1;
        chk("ld.rden", 32'(MemRdEn), 1);
        chk("ld.maddr", 32'(MemAddr), 32'h10);
        chk("ld.busy", 32'(Busy), 1);
        chk("ld.we_t1", 32'(WriteEn), 0);
        @(negedge Clk); #1;
        port_chk("ld.t2", 1, 1, 2, 8'hA5);
        chk("ld.rden_resp", 32'(MemRdEn), 0);
        @(negedge Clk); #1;
        chk("ld.idle_we", 32'(WriteEn), 0);
        chk("ld.idle_busy", 32'(Busy), 0);

        // ALU bumps the load into HOLD
        @(negedge Clk); LdValid = 1; LdDest = 1; LdAddr = 2; LdMemAddr = 8'h10;
        @(negedge Clk); LdValid = 0;
        @(negedge Clk); AluValid = 1; AluDest = 0; AluAddr = 0; AluData = 8'h3C;
        #1; port_chk("bump.resp", 1, 0, 0, 8'h3C); chk("bump.resp_stall", 32'(AluStall), 0);
        @(negedge Clk); AluData = 8'h11;
        #1; port_chk("bump.hold", 1, 1, 2, 8'hA5); chk("bump.hold_stall", 32'(AluStall), 1);
        @(negedge Clk);
        #1; port_chk("bump.retry", 1, 0, 0, 8'h11); chk("bump.retry_stall", 32'(AluStall), 0);
        @(negedge Clk); AluValid = 0;

        // hazard: ALU to reg1 waits behind a load to reg1
        @(negedge Clk); LdValid = 1; LdDest = 1; LdAddr = 1; LdMemAddr = 8'h20;
        @(negedge Clk); LdValid = 0; AluValid = 1; AluDest = 1; AluAddr = 1; AluData = 8'h99;
        #1; chk("haz.q_stall", 32'(AluStall), 1); chk("haz.q_we", 32'(WriteEn), 0);
        @(negedge Clk);
        #1; chk("haz.resp_stall", 32'(AluStall), 1); port_chk("haz.resp", 1, 1, 1, 8'h77);
        @(negedge Clk);
        #1; chk("haz.after_stall", 32'(AluStall), 0); port_chk("haz.after", 1, 1, 1, 8'h99);
        @(negedge Clk); AluValid = 0;

        // no hazard: ALU to reg3 while the reg1 load is pending
        @(negedge Clk); LdValid = 1; LdDest = 1; LdAddr = 1; LdMemAddr = 8'h20;
        @(negedge Clk); LdValid = 0; AluValid = 1; AluDest = 1; AluAddr = 3; AluData = 8'h33;
        #1; chk("nohaz.stall", 32'(AluStall), 0); port_chk("nohaz.alu", 1, 1, 3, 8'h33);
        chk("nohaz.rden", 32'(MemRdEn), 1);
        @(negedge Clk); AluValid = 0;
        #1; port_chk("nohaz.ld", 1, 1, 1, 8'h77);
        @(negedge Clk);

        // back-pressure: LdValid held 8 cycles into a 2-deep queue
        @(negedge Clk);
        wr_log.delete(); acc_q.delete(); saw_nr = 0; ma = 8'h00;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) @(negedge Clk);
            LdValid = 1; LdDest = 1; LdMemAddr = ma; LdAddr = ma[1:0];
            #1;
            if (!LdReady) saw_nr = 1;
            else begin
                acc_q.push_back(ma);
                ma = ma + 8'd1;
            end
        end
        @(negedge Clk); LdValid = 0;
        cyc = 0;
        #1;
        while (Busy && cyc < 40) begin
            @(negedge Clk); #1; cyc++;
        end
        chk("bp.busy_drain", 32'(Busy), 0);
        chk("bp.not_ready_seen", 32'(saw_nr), 1);
        chk("bp.accepted", 32'(acc_q.size()), 5);
        chk("bp.writes", 32'(wr_log.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_log.size() && i < acc_q.size())
                chk($sformatf("bp.wr%0d", i), 32'(wr_log[i]),
                    32'({1'b1, acc_q[i][1:0], 8'hC0 + acc_q[i]}));
        end
        repeat (3) @(negedge Clk);
        chk("bp.no_extra", 32'(wr_log.size()), 5);

        // reset during RESP of a load to the accumulator
        @(negedge Clk); LdValid = 1; LdDest = 0; LdAddr = 0; LdMemAddr = 8'h30;
        @(negedge Clk); LdValid = 0;
        #1; chk("rr.rden", 32'(MemRdEn), 1);
        @(negedge Clk); Reset = 1'b0; wr_log.delete();
        AluValid = 1; AluDest = 0; AluData = 8'hEE;
        #1;
        chk("rr.we", 32'(WriteEn), 0);
        chk("rr.rden0", 32'(MemRdEn), 0);
        chk("rr.stall", 32'(AluStall), 0);
        chk("rr.busy", 32'(Busy), 0);
        chk("rr.ready", 32'(LdReady), 1);
        @(negedge Clk); AluValid = 0; Reset = 1'b1;
        repeat (4) @(negedge Clk);
        #3;
        chk("rr.no_stale", 32'(wr_log.size()), 0);
        chk("rr.busy_after", 32'(Busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
